// File: rtl/dlfloat16_square_seq.sv
// Multi-cycle DLFloat16 squarer: shift-add significand square, then normalise and round to nearest even.
// A square is never negative, so the operand sign is dropped and the result sign is always 0.
module dlfloat16_square_seq #(
    parameter int BIAS    = 31,
    parameter int MAX_EXP = 62
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dl_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] dl_out,
    output logic [4:0]  exception_flags
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  exp_q, exp_d;
    logic [9:0]  m_q, m_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] dl_out_q, dl_out_d;
    logic [4:0]  flags_q, flags_d;

    logic        accept;
    logic        in_special;
    logic        unused_sign;

    logic               n;
    logic [8:0]         frac_trunc;
    logic               guard;
    logic               sticky;
    logic               round_up;
    logic [9:0]         frac_sum;
    logic               inexact;
    logic signed [9:0]  e_base;
    logic signed [9:0]  e_fin;

    assign unused_sign = dl_in[15];
    assign accept      = in_valid && in_ready;
    assign in_special  = (dl_in[14:9] == 6'd63) || (dl_in[14:9] == 6'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = in_special ? DONE : MUL;
            MUL:  if (cnt_q == 4'd9) state_d = NORM;
            NORM: state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Normalisation picks the 9 fraction bits below the leading one of the 20-bit square.
    always_comb begin
        n          = acc_q[19];
        frac_trunc = n ? acc_q[18:10] : acc_q[17:9];
        guard      = n ? acc_q[9] : acc_q[8];
        sticky     = n ? (|acc_q[8:0]) : (|acc_q[7:0]);
        round_up   = guard && (sticky || frac_trunc[0]);
        frac_sum   = {1'b0, frac_trunc} + {9'b0, round_up};
        inexact    = guard | sticky;
        e_base     = $signed({3'b000, exp_q, 1'b0}) - $signed(10'(BIAS));
        e_fin      = e_base + $signed({9'b0, n}) + $signed({9'b0, frac_sum[9]});
    end

    always_comb begin
        exp_d    = exp_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dl_out_d = dl_out_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    exp_d = dl_in[14:9];
                    if (dl_in[14:9] == 6'd63) begin
                        dl_out_d = 16'h7FFF;
                        flags_d  = 5'b10000;
                    end else if (dl_in[14:9] == 6'd0) begin
                        dl_out_d = 16'h0000;
                        flags_d  = 5'b00000;
                    end else begin
                        m_d   = {1'b1, dl_in[8:0]};
                        acc_d = 20'd0;
                        cnt_d = 4'd0;
                    end
                end
            end
            MUL: begin
                if (m_q[cnt_q]) begin
                    acc_d = acc_q + ({10'b0, m_q} << cnt_q);
                end
                cnt_d = cnt_q + 4'd1;
            end
            NORM: begin
                if (e_fin > $signed(10'(MAX_EXP))) begin
                    dl_out_d = 16'h7DFF;
                    flags_d  = 5'b01100;
                end else if (e_fin < $signed(10'sd1)) begin
                    dl_out_d = 16'h0000;
                    flags_d  = 5'b01010;
                end else begin
                    dl_out_d = {1'b0, e_fin[5:0], frac_sum[8:0]};
                    flags_d  = {1'b0, inexact, 3'b000};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= 6'd0;
            m_q      <= 10'd0;
            acc_q    <= 20'd0;
            cnt_q    <= 4'd0;
            dl_out_q <= 16'h0000;
            flags_q  <= 5'b00000;
        end else begin
            exp_q    <= exp_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dl_out_q <= dl_out_d;
            flags_q  <= flags_d;
        end
    end

    assign dl_out          = dl_out_q;
    assign exception_flags = flags_q;

endmodule

// File: tb/tb_dlfloat16_square_seq.sv
// Scoreboard bench for dlfloat16_square_seq: driver queues expected results, a negedge monitor checks them.
module tb_dlfloat16_square_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dl_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dl_out;
    logic [4:0]  exception_flags;

    typedef struct {
        logic [15:0] res;
        logic [4:0]  flg;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit busy        = 0;
    bit lat_checked = 0;
    int lat         = 0;

    dlfloat16_square_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dl_in           (dl_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .dl_out          (dl_out),
        .exception_flags (exception_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: latency counted in negedges after the accepting edge; data checked on the handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy        = 0;
            lat_checked = 0;
        end else begin
            if (busy) lat++;
            if (out_valid && !lat_checked) begin
                lat_checked = 1;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput({sb[0].name, "_latency"}, 32'(lat), 32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() != 0) begin
                    cur = sb.pop_front();
                    checkOutput({cur.name, "_dl_out"}, 32'(dl_out), 32'(cur.res));
                    checkOutput({cur.name, "_flags"}, 32'(exception_flags), 32'(cur.flg));
                end
                busy = 0;
            end
            if (in_valid && in_ready) begin
                busy        = 1;
                lat         = 0;
                lat_checked = 0;
            end
        end
    end

    task automatic issueOp(input string name, input logic [15:0] x, input bit track,
                           input logic [15:0] res, input logic [4:0] flg, input int exp_lat);
        exp_t e;
        bit accepted;
        accepted = 0;
        if (track) begin
            e.res  = res;
            e.flg  = flg;
            e.lat  = exp_lat;
            e.name = name;
            sb.push_back(e);
        end
        dl_in    = x;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
            if (track && sb.size() != 0) void'(sb.pop_back());
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checkOutput({name, "_drain_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input string name, input logic [15:0] x,
                                 input logic [15:0] res, input logic [4:0] flg, input int exp_lat);
        issueOp(name, x, 1'b1, res, flg, exp_lat);
        waitDrain(name);
    endtask

    // Independent round-to-nearest-even reference for exponent 31 (value in [1,2)).
    function automatic void refSquare(input logic [8:0] f, output logic [15:0] res, output logic [4:0] flg);
        longint m, p, d, q, r, half;
        int nn;
        m    = 512 + longint'(f);
        p    = m * m;
        nn   = (p >= (longint'(1) << 19)) ? 1 : 0;
        d    = (nn == 1) ? 1024 : 512;
        q    = p / d;
        r    = p % d;
        half = d / 2;
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == 1024) begin
            q  = 512;
            nn = nn + 1;
        end
        res = {1'b0, 6'(31 + nn), 9'(q - 512)};
        flg = {1'b0, (r != 0), 3'b000};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        logic [15:0] rres;
        logic [4:0]  rflg;
        bit          saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dl_in     = 16'h0000;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_dl_out", 32'(dl_out), 32'h0000);
        checkOutput("reset_flags", 32'(exception_flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("one",      16'h3E00, 16'h3E00, 5'b00000, 12);
        checkOutput("hold_last_result", 32'(dl_out), 32'h3E00);
        applyStimulus("two",      16'h4000, 16'h4200, 5'b00000, 12);
        applyStimulus("one_half", 16'h3F00, 16'h4040, 5'b00000, 12);
        applyStimulus("neg_1p5",  16'hBF00, 16'h4040, 5'b00000, 12);
        applyStimulus("rnd_down", 16'h3E01, 16'h3E02, 5'b01000, 12);
        applyStimulus("overflow", 16'h6000, 16'h7DFF, 5'b01100, 12);
        applyStimulus("underflw", 16'h1400, 16'h0000, 5'b01010, 12);
        applyStimulus("nan",      16'h7FFF, 16'h7FFF, 5'b10000, 1);
        applyStimulus("zero",     16'h0000, 16'h0000, 5'b00000, 1);

        // Backpressure: the result must sit unchanged while the consumer stalls.
        out_ready = 1'b0;
        issueOp("hold", 16'h3F00, 1'b1, 16'h4040, 5'b00000, 12);
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_dl_out", 32'(dl_out), 32'h4040);
            checkOutput("hold_flags", 32'(exception_flags), 32'd0);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain("hold");

        // Reset in the middle of MUL discards the operation.
        issueOp("reset_mid", 16'h3E00, 1'b0, 16'h0000, 5'b00000, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_valid = 0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        checkOutput("reset_no_output", 32'(saw_valid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus("after_reset", 16'h3F00, 16'h4040, 5'b00000, 12);

        for (int f = 0; f < 512; f++) begin
            refSquare(9'(f), rres, rflg);
            applyStimulus($sformatf("sweep_%0d", f), {1'b0, 6'd31, 9'(f)}, rres, rflg, 12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dlfloat16_square_seq.md
Name: dlfloat16_square_seq

Overview:
- Multi-cycle DLFloat16 squarer (y = x*x); the inverse companion of the FPU's square-root unit, used for sqrt result checking and norm computation.
- Consumes one 16-bit DLFloat16 operand (1 sign, 6 exponent bias 31, 9 fraction) over a valid/ready handshake.
- Squares the 10-bit significand with a shift-add iterative multiplier, normalises and rounds (round-to-nearest-even).
- Returns a 16-bit DLFloat16 result plus the FPU's 5-bit exception flag vector.

Parameters:
- BIAS, 31, exponent bias.
- MAX_EXP, 62, largest finite biased exponent; exponent 63 is reserved for NaN.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- dl_in  input  16  DLFloat16 operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- dl_out  output  16  DLFloat16 result.
- exception_flags  output  5  {invalid, inexact, overflow, underflow, div_by_zero}; div_by_zero is always 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; dl_out=16'h0000; exception_flags=5'b0. A reset mid-operation discards the operand, and no result is emitted.
- States: IDLE, MUL, NORM, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid&&in_ready, latch the operand and classify it:
  - exp==63 (NaN): result 16'h7FFF, invalid=1; go to DONE.
  - exp==0 (zero, no subnormals): result 16'h0000, no flags; go to DONE.
  - Otherwise: m={1,frac} (10 bits), acc=0, cnt=0; go to MUL.
- The input sign is ignored; the result sign is always 0.
- MUL: each cycle, if m[cnt] then acc += m<<cnt (20-bit acc); cnt++. After 10 cycles (cnt==9 processed), go to NORM.
- NORM (1 cycle):
  - e = 2*exp - BIAS, computed as signed 9-bit.
  - If acc[19]: n=1, fraction=acc[18:10], guard=acc[9], sticky=|acc[8:0]. Else: n=0, fraction=acc[17:9], guard=acc[8], sticky=|acc[7:0].
  - Round up when guard && (sticky || fraction[0]). Fraction 511+1 wraps to 0 and carries +1 into the exponent.
  - Final e' = e + n + carry. inexact = guard|sticky.
  - e' > MAX_EXP: result 16'h7DFF (saturate), overflow=1, inexact=1.
  - e' < 1: result 16'h0000, underflow=1, inexact=1.
  - Otherwise: result {1'b0, e'[5:0], fraction}.
  - Go to DONE.
- DONE: out_valid=1. dl_out and exception_flags are registered and stable while out_valid && !out_ready. On out_ready: out_valid=0, return to IDLE (in_ready=1 the next cycle).
- Latency from the acceptance edge to out_valid high:
  - Finite operands: 12 cycles (10 MUL + 1 NORM + 1 DONE entry).
  - Specials: 1 cycle.
- Throughput: one operation in flight. in_valid while not in IDLE is ignored; the upstream holds the operand.
- dl_out and exception_flags keep the last result after the handshake until the next result is loaded.

Test Plan:
- 16'h3E00 (1.0) -> after 12 cycles dl_out=16'h3E00, flags=5'b00000. Then 16'h4000 (2.0) -> 16'h4200, flags=0.
- 16'h3F00 (1.5) -> 16'h4040 (2.25) exact, flags=0. 16'hBF00 (-1.5) -> 16'h4040 (sign cleared).
- 16'h3E01 -> 16'h3E02, flags=5'b01000 (inexact, round down). Also sweep all 512 fractions at exp 31 against a round-to-nearest-even reference model.
- Overflow: exp 48 (16'h6000) -> 16'h7DFF, flags=5'b01100. Underflow: exp 10 (16'h1400) -> 16'h0000, flags=5'b01010.
- Specials: 16'h7FFF -> 16'h7FFF, flags=5'b10000. 16'h0000 -> 16'h0000, flags=0. Each returns 1 cycle after acceptance.
- Handshake: hold out_ready=0 for 5 cycles -> out_valid, dl_out and flags stable, in_ready=0. Assert rst_n=0 during MUL -> out_valid never rises, in_ready=1 after reset release, and the next operand computes correctly.
